// File: rtl/countdown_mmss_bcd_if.sv
// Control and display bundle for the MM:SS BCD countdown timer.
// The master drives the controls and preset digits; the slave is the timer.
interface countdown_mmss_bcd_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] set_min1;
    logic [3:0] set_min0;
    logic [3:0] set_sec1;
    logic [3:0] set_sec0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic       borrow_out;
    logic       running;
    logic       expired;
    logic       alarm;
    logic       load_err;

    modport master (
        output tick, load, start, pause, set_min1, set_min0, set_sec1, set_sec0,
        input  min1, min0, sec1, sec0, borrow_out, running, expired, alarm, load_err
    );

    modport slave (
        input  tick, load, start, pause, set_min1, set_min0, set_sec1, set_sec0,
        output min1, min0, sec1, sec0, borrow_out, running, expired, alarm, load_err
    );
endinterface

// File: rtl/countdown_mmss_bcd.sv
// BCD MM:SS countdown timer with expiry pulse and timed buzzer request.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry and keep counting.
module countdown_mmss_bcd #(
    parameter int BEEP_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    countdown_mmss_bcd_if.slave  bus
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [8:0] BEEP_LIMIT = 9'(BEEP_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } state_t;

    state_t      state_reg;
    logic [15:0] value_reg;
    logic [15:0] preset_reg;
    logic [7:0]  beep_reg;
    logic        running_reg;
    logic        expired_reg;
    logic        alarm_reg;
    logic        load_err_reg;

    logic [15:0] preset_in;
    logic [3:0]  digit_ok;
    logic        preset_ok;
    logic [15:0] dec_value;
    logic [15:0] expire_value;
    logic [8:0]  beep_inc;
    logic        beep_can_inc;
    logic        beep_done;
    logic        at_one;
    logic        value_nonzero;

    assign preset_in = {bus.set_min1, bus.set_min0, bus.set_sec1, bus.set_sec0};

    // Even digit positions are units (0-9), odd positions are tens (0-5).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_chk
            localparam logic [3:0] DIGIT_MAX = (gi % 2 == 0) ? 4'd9 : 4'd5;
            assign digit_ok[gi] = (preset_in[gi*4 +: 4] <= DIGIT_MAX);
        end
    endgenerate

    assign preset_ok     = &digit_ok;
    assign at_one        = (value_reg == 16'h0001);
    assign value_nonzero = (value_reg != 16'h0000);
    assign expire_value  = AUTO_RELOAD ? preset_reg : 16'h0000;
    assign beep_inc      = {1'b0, beep_reg} + 9'd1;
    assign beep_can_inc  = ({1'b0, beep_reg} < BEEP_LIMIT);
    assign beep_done     = (beep_inc >= BEEP_LIMIT);

    // One-second BCD decrement with borrow ripple sec0 -> sec1 -> min0 -> min1.
    always_comb begin
        dec_value = value_reg;
        if (value_reg[3:0] != 4'd0) begin
            dec_value[3:0] = value_reg[3:0] - 4'd1;
        end else begin
            dec_value[3:0] = 4'd9;
            if (value_reg[7:4] != 4'd0) begin
                dec_value[7:4] = value_reg[7:4] - 4'd1;
            end else begin
                dec_value[7:4] = 4'd5;
                if (value_reg[11:8] != 4'd0) begin
                    dec_value[11:8] = value_reg[11:8] - 4'd1;
                end else begin
                    dec_value[11:8]  = 4'd9;
                    dec_value[15:12] = value_reg[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            value_reg    <= 16'h0000;
            preset_reg   <= 16'h0000;
            beep_reg     <= 8'd0;
            running_reg  <= 1'b0;
            expired_reg  <= 1'b0;
            alarm_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            expired_reg  <= 1'b0;
            load_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_PAUSE: begin
                    if (bus.load) begin
                        if (preset_ok) begin
                            value_reg   <= preset_in;
                            preset_reg  <= preset_in;
                            state_reg   <= ST_IDLE;
                            running_reg <= 1'b0;
                        end else begin
                            load_err_reg <= 1'b1;
                        end
                    end else if (bus.start && value_nonzero) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Beep window that runs alongside counting in reload mode.
                    if (AUTO_RELOAD && alarm_reg) begin
                        if (bus.start || bus.pause) begin
                            alarm_reg <= 1'b0;
                        end else if (bus.tick) begin
                            if (beep_can_inc) beep_reg <= beep_inc[7:0];
                            if (beep_done) alarm_reg <= 1'b0;
                        end
                    end
                    if (bus.tick && at_one) begin
                        expired_reg <= 1'b1;
                        alarm_reg   <= 1'b1;
                        beep_reg    <= 8'd0;
                        value_reg   <= expire_value;
                        if (!AUTO_RELOAD) begin
                            state_reg   <= ST_ALARM;
                            running_reg <= 1'b0;
                        end
                    end else begin
                        if (bus.tick) value_reg <= dec_value;
                        if (bus.pause) begin
                            state_reg   <= ST_PAUSE;
                            running_reg <= 1'b0;
                        end
                    end
                end
                ST_ALARM: begin
                    if (bus.start || bus.pause) begin
                        alarm_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (bus.tick) begin
                        if (beep_can_inc) beep_reg <= beep_inc[7:0];
                        if (beep_done) begin
                            alarm_reg <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.min1       = value_reg[15:12];
    assign bus.min0       = value_reg[11:8];
    assign bus.sec1       = value_reg[7:4];
    assign bus.sec0       = value_reg[3:0];
    assign bus.borrow_out = (value_reg[7:0] == 8'h00);
    assign bus.running    = running_reg;
    assign bus.expired    = expired_reg;
    assign bus.alarm      = alarm_reg;
    assign bus.load_err   = load_err_reg;

endmodule

// File: tb/tb_countdown_mmss_bcd.sv
// Directed self-checking bench for the MM:SS countdown timer.
module tb_countdown_mmss_bcd;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    countdown_mmss_bcd_if bus ();

    countdown_mmss_bcd #(.BEEP_TICKS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cur_value();
        return {bus.min1, bus.min0, bus.sec1, bus.sec0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
            $error("check %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls, then sample 1 ns after the edge.
    task automatic cyc(input logic t, input logic l, input logic s, input logic p);
        bus.tick  = t;
        bus.load  = l;
        bus.start = s;
        bus.pause = p;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic set_preset(input logic [3:0] m1, input logic [3:0] m0,
                              input logic [3:0] s1, input logic [3:0] s0);
        bus.set_min1 = m1;
        bus.set_min0 = m0;
        bus.set_sec1 = s1;
        bus.set_sec0 = s0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_value", cur_value(), 16'h0000);
        chk("rst_running", 16'(bus.running), 16'd0);
        chk("rst_alarm", 16'(bus.alarm), 16'd0);
        chk("rst_expired", 16'(bus.expired), 16'd0);
        chk("rst_load_err", 16'(bus.load_err), 16'd0);
        chk("rst_borrow", 16'(bus.borrow_out), 16'd1);
        rst = 1'b0;
        $display("step reset done");

        // Reset mid-RUN
        set_preset(4'd0, 4'd3, 4'd2, 4'd8);
        cyc(0, 1, 0, 0);
        chk("load_0328", cur_value(), 16'h0328);
        cyc(0, 0, 1, 0);
        chk("start_running", 16'(bus.running), 16'd1);
        cyc(1, 0, 0, 0);
        chk("tick_0327", cur_value(), 16'h0327);
        chk("borrow_0327", 16'(bus.borrow_out), 16'd0);
        rst = 1'b1;
        cyc(1, 0, 0, 0);
        rst = 1'b0;
        chk("midrun_rst_value", cur_value(), 16'h0000);
        chk("midrun_rst_running", 16'(bus.running), 16'd0);
        chk("midrun_rst_alarm", 16'(bus.alarm), 16'd0);
        chk("midrun_rst_borrow", 16'(bus.borrow_out), 16'd1);
        cyc(0, 0, 1, 0);
        chk("start_at_zero", 16'(bus.running), 16'd0);
        $display("step reset mid-run done");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Full countdown 01:00 to expiry and beep window
        set_preset(4'd0, 4'd1, 4'd0, 4'd0);
        cyc(0, 1, 0, 0);
        chk("load_0100", cur_value(), 16'h0100);
        chk("borrow_0100", 16'(bus.borrow_out), 16'd1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("tick_0059", cur_value(), 16'h0059);
        ticks(58);
        chk("at_0001", cur_value(), 16'h0001);
        chk("no_early_expired", 16'(bus.expired), 16'd0);
        cyc(1, 0, 0, 0);
        chk("expiry_value", cur_value(), 16'h0000);
        chk("expiry_pulse", 16'(bus.expired), 16'd1);
        chk("expiry_alarm", 16'(bus.alarm), 16'd1);
        chk("expiry_running", 16'(bus.running), 16'd0);
        cyc(0, 0, 0, 0);
        chk("expired_one_cycle", 16'(bus.expired), 16'd0);
        ticks(9);
        chk("alarm_after_9", 16'(bus.alarm), 16'd1);
        cyc(1, 0, 0, 0);
        chk("alarm_after_10", 16'(bus.alarm), 16'd0);
        cyc(0, 0, 1, 0);
        chk("idle_after_beep", 16'(bus.running), 16'd0);
        $display("step full countdown done");
`endif

        // Minute borrow, invalid load in PAUSE
        set_preset(4'd1, 4'd0, 4'd0, 4'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("tick_0959", cur_value(), 16'h0959);
        cyc(0, 0, 0, 1);
        chk("pause_running", 16'(bus.running), 16'd0);
        set_preset(4'd6, 4'd10, 4'd0, 4'd0);
        cyc(0, 1, 0, 0);
        chk("bad_load_err", 16'(bus.load_err), 16'd1);
        chk("bad_load_value", cur_value(), 16'h0959);
        cyc(1, 0, 0, 0);
        chk("load_err_one_cycle", 16'(bus.load_err), 16'd0);
        chk("pause_tick_ignored", cur_value(), 16'h0959);
        $display("step minute borrow done");

        // Tick together with pause
        set_preset(4'd0, 4'd0, 4'd0, 4'd5);
        cyc(0, 1, 0, 0);
        chk("load_0005_value", cur_value(), 16'h0005);
        chk("load_0005_idle", 16'(bus.running), 16'd0);
        cyc(0, 0, 1, 0);
        ticks(2);
        chk("tick_0003", cur_value(), 16'h0003);
        cyc(1, 0, 0, 1);
        chk("tick_pause_value", cur_value(), 16'h0002);
        chk("tick_pause_state", 16'(bus.running), 16'd0);
        ticks(2);
        chk("pause_hold", cur_value(), 16'h0002);
        cyc(0, 0, 1, 0);
        chk("resume_running", 16'(bus.running), 16'd1);
        cyc(1, 0, 0, 0);
        chk("resume_0001", cur_value(), 16'h0001);
        set_preset(4'd0, 4'd0, 4'd0, 4'd9);
        cyc(0, 1, 0, 0);
        chk("run_load_ignored", cur_value(), 16'h0001);
        chk("run_load_no_err", 16'(bus.load_err), 16'd0);
        $display("step tick+pause done");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Alarm acknowledge
        cyc(1, 0, 0, 0);
        chk("expiry2_pulse", 16'(bus.expired), 16'd1);
        ticks(3);
        chk("alarm_before_ack", 16'(bus.alarm), 16'd1);
        cyc(0, 0, 1, 0);
        chk("ack_alarm", 16'(bus.alarm), 16'd0);
        chk("ack_value", cur_value(), 16'h0000);
        chk("ack_running", 16'(bus.running), 16'd0);
        $display("step alarm ack done");

        // start+pause priority, expiry beats pause
        set_preset(4'd0, 4'd0, 4'd3, 4'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("run_pause_wins", 16'(bus.running), 16'd0);
        cyc(0, 0, 1, 1);
        chk("pause_start_wins", 16'(bus.running), 16'd1);
        cyc(0, 0, 0, 1);
        set_preset(4'd0, 4'd0, 4'd0, 4'd1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk("expiry_over_pause", 16'(bus.expired), 16'd1);
        chk("expiry_over_pause_alarm", 16'(bus.alarm), 16'd1);
        cyc(0, 0, 0, 1);
        chk("pause_ack_alarm", 16'(bus.alarm), 16'd0);
        $display("step priority done");
`else
        // Auto reload: preset register is 00:05
        cyc(1, 0, 0, 0);
        chk("auto_expired", 16'(bus.expired), 16'd1);
        chk("auto_reload_value", cur_value(), 16'h0005);
        chk("auto_running", 16'(bus.running), 16'd1);
        chk("auto_alarm", 16'(bus.alarm), 16'd1);
        cyc(0, 0, 0, 1);
        chk("auto_pause_clears", 16'(bus.alarm), 16'd0);
        set_preset(4'd0, 4'd0, 4'd1, 4'd5);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        ticks(14);
        chk("auto_0001", cur_value(), 16'h0001);
        cyc(1, 0, 0, 0);
        chk("auto2_expired", 16'(bus.expired), 16'd1);
        chk("auto2_value", cur_value(), 16'h0015);
        ticks(9);
        chk("auto2_alarm_9", 16'(bus.alarm), 16'd1);
        chk("auto2_value_9", cur_value(), 16'h0006);
        cyc(1, 0, 0, 0);
        chk("auto2_alarm_10", 16'(bus.alarm), 16'd0);
        chk("auto2_value_10", cur_value(), 16'h0005);
        chk("auto2_running", 16'(bus.running), 16'd1);
        cyc(0, 0, 0, 1);
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("auto_zero_no_start", 16'(bus.running), 16'd0);
        $display("step auto reload done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
